// File: rtl/mem_router_pkg.sv
// Shared definitions for the core memory bus router: default address map
// constants and the router FSM state encoding.
package mem_router_pkg;

  localparam logic [31:0] BRAM_BASE  = 32'h0000_0000;
  localparam logic [31:0] BRAM_TOP   = 32'h0000_1000;
  localparam logic [31:0] UART_BASE  = 32'h0000_1000;
  localparam logic [31:0] UART_TOP   = 32'h0000_1004;
  localparam logic [31:0] TIMER_BASE = 32'h0000_2000;
  localparam logic [31:0] TIMER_TOP  = 32'h0000_2010;

  typedef logic [1:0] state_t;
  localparam state_t ST_IDLE = 2'd0;
  localparam state_t ST_BUSY = 2'd1;
  localparam state_t ST_ERR  = 2'd2;

endpackage

// File: rtl/mem_router_dec.sv
// Combinational priority address decoder: lowest matching slave index wins.
module mem_router_dec
  import mem_router_pkg::*;
#(
  parameter int                      NSLV     = 3,
  parameter int                      SELW     = $clog2(NSLV + 1),
  parameter logic [NSLV-1:0][31:0]   SLV_BASE = {NSLV{32'h0}},
  parameter logic [NSLV-1:0][31:0]   SLV_TOP  = {NSLV{32'h0}}
) (
  input  logic [31:0]     addr,
  output logic [SELW-1:0] sel,
  output logic            hit_any
);

  logic [NSLV-1:0] hit;

  for (genvar i = 0; i < NSLV; i++) begin : g_hit
    assign hit[i] = (addr >= SLV_BASE[i]) && (addr < SLV_TOP[i]);
  end

  // Scan from the top so the lowest index is the last (winning) assignment.
  always_comb begin
    sel = '0;
    for (int i = NSLV - 1; i >= 0; i--)
      if (hit[i]) sel = SELW'(i);
  end

  assign hit_any = |hit;

endmodule

// File: rtl/mem_router.sv
// Single-master, NSLV-slave memory bus router with a parameter-driven address
// map, one tracked outstanding transaction, unmapped-error and timeout responses.
module mem_router
  import mem_router_pkg::*;
#(
  parameter int                    NSLV        = 3,
  parameter logic [NSLV-1:0][31:0] SLV_BASE    = {NSLV{32'h0}},
  parameter logic [NSLV-1:0][31:0] SLV_TOP     = {NSLV{32'h0}},
  parameter int                    DEFAULT_SLV = 0,
  parameter int                    TIMEOUT     = 1024
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 mem_valid,
  input  logic                 mem_instr,
  input  logic [31:0]          mem_addr,
  input  logic [31:0]          mem_wdata,
  input  logic [3:0]           mem_wstrb,
  output logic [31:0]          mem_rdata,
  output logic                 mem_ready,
  output logic                 mem_error,
  output logic [NSLV-1:0]      slv_valid,
  output logic                 slv_instr,
  output logic [31:0]          slv_addr,
  output logic [31:0]          slv_wdata,
  output logic [3:0]           slv_wstrb,
  input  logic [NSLV*32-1:0]   slv_rdata,
  input  logic [NSLV-1:0]      slv_ready
);

  localparam int              SELW       = $clog2(NSLV + 1);
  localparam int              CW         = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [CW-1:0]   CNT_LAST   = CW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);
  localparam logic [CW-1:0]   CNT_ONE    = CW'(1);
  localparam logic [SELW-1:0] DEF_SEL    = SELW'(DEFAULT_SLV);
  localparam bit              DEF_MAPPED = (DEFAULT_SLV < NSLV);

  state_t          state;
  logic [SELW-1:0] cur;
  logic [CW-1:0]   cnt;
  logic [SELW-1:0] dec_sel, sel;
  logic            hit_any, mapped;
  logic            sel_ready, cur_ready;
  logic [31:0]     sel_rdata, cur_rdata;

  mem_router_dec #(
    .NSLV     (NSLV),
    .SELW     (SELW),
    .SLV_BASE (SLV_BASE),
    .SLV_TOP  (SLV_TOP)
  ) u_dec (
    .addr    (mem_addr),
    .sel     (dec_sel),
    .hit_any (hit_any)
  );

  assign sel    = hit_any ? dec_sel : DEF_SEL;
  assign mapped = hit_any || DEF_MAPPED;

  // Response muxes for the freshly decoded slave and the tracked one.
  always_comb begin
    sel_ready = 1'b0;
    sel_rdata = '0;
    cur_ready = 1'b0;
    cur_rdata = '0;
    for (int i = 0; i < NSLV; i++) begin
      if (sel == SELW'(i)) begin
        sel_ready = slv_ready[i];
        sel_rdata = slv_rdata[32*i +: 32];
      end
      if (cur == SELW'(i)) begin
        cur_ready = slv_ready[i];
        cur_rdata = slv_rdata[32*i +: 32];
      end
    end
  end

  always_comb begin
    slv_valid = '0;
    mem_ready = 1'b0;
    mem_error = 1'b0;
    mem_rdata = '0;
    if (rst) begin
      case (state)
        ST_IDLE: if (mem_valid && mapped) begin
          for (int i = 0; i < NSLV; i++) slv_valid[i] = (sel == SELW'(i));
          if (sel_ready) begin
            mem_ready = 1'b1;
            mem_rdata = sel_rdata;
          end
        end
        ST_BUSY: if (cur_ready) begin
          mem_ready = 1'b1;
          mem_rdata = cur_rdata;
        end
        ST_ERR: begin
          mem_ready = 1'b1;
          mem_error = 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign slv_instr = rst & mem_instr;
  assign slv_addr  = rst ? mem_addr  : '0;
  assign slv_wdata = rst ? mem_wdata : '0;
  assign slv_wstrb = rst ? mem_wstrb : '0;

  always_ff @(posedge clk) begin
    if (!rst) begin
      state <= ST_IDLE;
      cur   <= '0;
      cnt   <= '0;
    end else begin
      case (state)
        ST_IDLE: if (mem_valid) begin
          if (!mapped) begin
            state <= ST_ERR;
          end else if (!sel_ready) begin
            state <= ST_BUSY;
            cur   <= sel;
            cnt   <= '0;
          end
        end
        ST_BUSY: begin
          if (cnt != '1) cnt <= cnt + CNT_ONE;
          if (cur_ready)
            state <= ST_IDLE;
          else if (TIMEOUT != 0 && cnt == CNT_LAST)
            state <= ST_ERR;
        end
        ST_ERR:  state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_router.sv
// Scenario bench for mem_router: per-task inline timing checks plus a response
// scoreboard that pops expected {rdata, error} whenever mem_ready fires.
module tb_mem_router;
  import mem_router_pkg::*;

  localparam int NSLV = 3;
  localparam logic [NSLV-1:0][31:0] BASE = {TIMER_BASE, UART_BASE, BRAM_BASE};
  localparam logic [NSLV-1:0][31:0] TOP  = {TIMER_TOP,  UART_TOP,  BRAM_TOP};

  logic                clk = 1'b0;
  logic                rst;
  logic                mem_valid, mem_instr;
  logic [31:0]         mem_addr, mem_wdata;
  logic [3:0]          mem_wstrb;
  logic [31:0]         mem_rdata;
  logic                mem_ready, mem_error;
  logic [NSLV-1:0]     slv_valid;
  logic                slv_instr;
  logic [31:0]         slv_addr, slv_wdata;
  logic [3:0]          slv_wstrb;
  logic [NSLV*32-1:0]  slv_rdata;
  logic [NSLV-1:0]     slv_ready;

  typedef struct packed { logic [31:0] rdata; logic err; } rsp_t;
  rsp_t exp_q[$];
  rsp_t exp_r;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  mem_router #(
    .NSLV(NSLV), .SLV_BASE(BASE), .SLV_TOP(TOP), .DEFAULT_SLV(3), .TIMEOUT(8)
  ) dut (
    .clk(clk), .rst(rst),
    .mem_valid(mem_valid), .mem_instr(mem_instr), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb),
    .mem_rdata(mem_rdata), .mem_ready(mem_ready), .mem_error(mem_error),
    .slv_valid(slv_valid), .slv_instr(slv_instr), .slv_addr(slv_addr),
    .slv_wdata(slv_wdata), .slv_wstrb(slv_wstrb),
    .slv_rdata(slv_rdata), .slv_ready(slv_ready)
  );

  // Scoreboard: every response strobe must match the oldest expectation.
  always @(negedge clk) begin
    if (rst === 1'b1 && mem_ready === 1'b1) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL sb_unexpected: got ready rdata=%h err=%b, expected no response", mem_rdata, mem_error);
      end else begin
        exp_r = exp_q.pop_front();
        if (mem_rdata !== exp_r.rdata || mem_error !== exp_r.err) begin
          errors++;
          $display("FAIL sb_rsp: got rdata=%h err=%b, expected rdata=%h err=%b",
                   mem_rdata, mem_error, exp_r.rdata, exp_r.err);
        end
      end
    end
  end

  task automatic idle_in();
    mem_valid = 1'b0; mem_instr = 1'b0; mem_addr = '0; mem_wdata = '0; mem_wstrb = '0;
    slv_ready = '0; slv_rdata = '0;
  endtask

  task automatic next();
    @(posedge clk); #1;
  endtask

  task automatic smp();
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b0;
    idle_in();
    mem_valid = 1'b1; mem_addr = 32'h1000; mem_wdata = 32'hDEAD_BEEF; mem_wstrb = 4'hF;
    mem_instr = 1'b1; slv_ready = 3'b111; slv_rdata = {3{32'h1234_5678}};
    next(); next(); smp();
    checks++; if (slv_valid !== 3'b000) begin errors++; $display("FAIL rst_slv_valid: got %b, expected 000", slv_valid); end
    checks++; if ({slv_instr, slv_addr, slv_wdata, slv_wstrb} !== 69'h0) begin errors++;
      $display("FAIL rst_broadcast: got instr=%b addr=%h wdata=%h wstrb=%h, expected all 0", slv_instr, slv_addr, slv_wdata, slv_wstrb); end
    checks++; if ({mem_ready, mem_error, mem_rdata} !== 34'h0) begin errors++;
      $display("FAIL rst_mem_out: got ready=%b err=%b rdata=%h, expected 0", mem_ready, mem_error, mem_rdata); end
    next();
    idle_in();
    rst = 1'b1;
    next();
  endtask

  task automatic test_uart_read();
    mem_valid = 1'b1; mem_addr = 32'h1000;
    smp();
    checks++; if (slv_valid !== 3'b010) begin errors++; $display("FAIL uart_req_valid: got %b, expected 010", slv_valid); end
    checks++; if (slv_addr !== 32'h1000) begin errors++; $display("FAIL uart_req_addr: got %h, expected 00001000", slv_addr); end
    next();
    idle_in();
    slv_rdata[32*1 +: 32] = 32'h41;  // data present but not yet strobed
    for (int c = 1; c <= 2; c++) begin
      smp();
      checks++; if (slv_valid !== 3'b000 || mem_ready !== 1'b0 || mem_rdata !== 32'h0) begin errors++;
        $display("FAIL uart_wait%0d: got valid=%b ready=%b rdata=%h, expected 000/0/0", c, slv_valid, mem_ready, mem_rdata); end
      next();
    end
    slv_ready = 3'b010;
    exp_q.push_back('{rdata: 32'h41, err: 1'b0});
    smp();
    checks++; if (mem_ready !== 1'b1 || mem_error !== 1'b0) begin errors++;
      $display("FAIL uart_rsp: got ready=%b err=%b, expected 1/0", mem_ready, mem_error); end
    next();
    idle_in();
    smp();
    checks++; if (mem_ready !== 1'b0) begin errors++; $display("FAIL uart_after: got ready=%b, expected 0", mem_ready); end
    next();
  endtask

  task automatic test_back_to_back();
    mem_valid = 1'b1; mem_addr = 32'h0; mem_instr = 1'b1;
    slv_ready = 3'b001; slv_rdata[31:0] = 32'h1234_5678;
    exp_q.push_back('{rdata: 32'h1234_5678, err: 1'b0});
    smp();
    checks++; if (slv_valid !== 3'b001 || slv_instr !== 1'b1) begin errors++;
      $display("FAIL bram_req: got valid=%b instr=%b, expected 001/1", slv_valid, slv_instr); end
    checks++; if (mem_ready !== 1'b1 || mem_rdata !== 32'h1234_5678) begin errors++;
      $display("FAIL bram_same_cycle: got ready=%b rdata=%h, expected 1/12345678", mem_ready, mem_rdata); end
    next();
    idle_in();
    mem_valid = 1'b1; mem_addr = 32'h1000; mem_wdata = 32'hA5; mem_wstrb = 4'b0001;
    smp();
    checks++; if (slv_valid !== 3'b010) begin errors++; $display("FAIL b2b_valid: got %b, expected 010 (router not idle)", slv_valid); end
    checks++; if (slv_wdata !== 32'hA5 || slv_wstrb !== 4'b0001 || mem_ready !== 1'b0) begin errors++;
      $display("FAIL b2b_write: got wdata=%h wstrb=%b ready=%b, expected a5/0001/0", slv_wdata, slv_wstrb, mem_ready); end
    next();
    idle_in();
    slv_ready = 3'b010;
    exp_q.push_back('{rdata: 32'h0, err: 1'b0});
    smp();
    checks++; if (mem_ready !== 1'b1) begin errors++; $display("FAIL b2b_rsp: got ready=%b, expected 1", mem_ready); end
    next();
    idle_in();
  endtask

  task automatic test_unmapped();
    mem_valid = 1'b1; mem_addr = 32'h3000;
    exp_q.push_back('{rdata: 32'h0, err: 1'b1});
    smp();
    checks++; if (slv_valid !== 3'b000 || mem_ready !== 1'b0) begin errors++;
      $display("FAIL unmap_req: got valid=%b ready=%b, expected 000/0", slv_valid, mem_ready); end
    next();
    idle_in();
    smp();
    checks++; if (mem_ready !== 1'b1 || mem_error !== 1'b1 || mem_rdata !== 32'h0) begin errors++;
      $display("FAIL unmap_rsp: got ready=%b err=%b rdata=%h, expected 1/1/0", mem_ready, mem_error, mem_rdata); end
    next();
    smp();
    checks++; if (mem_ready !== 1'b0 || mem_error !== 1'b0) begin errors++;
      $display("FAIL unmap_after: got ready=%b err=%b, expected 0/0", mem_ready, mem_error); end
    next();
  endtask

  task automatic test_ignore_other();
    mem_valid = 1'b1; mem_addr = 32'h2000;
    smp();
    checks++; if (slv_valid !== 3'b100) begin errors++; $display("FAIL timer_req: got %b, expected 100", slv_valid); end
    next();
    idle_in();
    slv_ready = 3'b010; slv_rdata[32*1 +: 32] = 32'hFF;
    smp();
    checks++; if (mem_ready !== 1'b0 || mem_rdata !== 32'h0) begin errors++;
      $display("FAIL other_ready: got ready=%b rdata=%h, expected 0/0", mem_ready, mem_rdata); end
    next();
    idle_in();
    slv_ready = 3'b100; slv_rdata[32*2 +: 32] = 32'h7;
    exp_q.push_back('{rdata: 32'h7, err: 1'b0});
    smp();
    checks++; if (mem_ready !== 1'b1 || mem_rdata !== 32'h7) begin errors++;
      $display("FAIL timer_rsp: got ready=%b rdata=%h, expected 1/7", mem_ready, mem_rdata); end
    next();
    idle_in();
  endtask

  task automatic test_timeout();
    mem_valid = 1'b1; mem_addr = 32'h2004;
    exp_q.push_back('{rdata: 32'h0, err: 1'b1});
    next();
    idle_in();
    for (int c = 1; c <= 8; c++) begin
      if (c == 3) begin mem_valid = 1'b1; mem_addr = 32'h0; end
      smp();
      checks++; if (mem_ready !== 1'b0 || slv_valid !== 3'b000) begin errors++;
        $display("FAIL to_wait%0d: got ready=%b valid=%b, expected 0/000", c, mem_ready, slv_valid); end
      next();
      idle_in();
    end
    smp();
    checks++; if (mem_ready !== 1'b1 || mem_error !== 1'b1) begin errors++;
      $display("FAIL to_rsp: got ready=%b err=%b at +9, expected 1/1", mem_ready, mem_error); end
    next();
    for (int c = 10; c <= 12; c++) begin
      if (c == 12) begin slv_ready = 3'b100; slv_rdata[32*2 +: 32] = 32'h99; end
      smp();
      checks++; if (mem_ready !== 1'b0) begin errors++; $display("FAIL to_stale%0d: got ready=%b, expected 0", c, mem_ready); end
      next();
      idle_in();
    end
  endtask

  task automatic test_reset_mid();
    mem_valid = 1'b1; mem_addr = 32'h1000;
    smp();
    checks++; if (slv_valid !== 3'b010) begin errors++; $display("FAIL rm_req: got %b, expected 010", slv_valid); end
    next();
    idle_in();
    rst = 1'b0; slv_ready = 3'b010; slv_rdata[32*1 +: 32] = 32'h55;
    smp();
    checks++; if (mem_ready !== 1'b0 || mem_rdata !== 32'h0) begin errors++;
      $display("FAIL rm_in_reset: got ready=%b rdata=%h, expected 0/0", mem_ready, mem_rdata); end
    next();
    idle_in();
    rst = 1'b1;
    next();
    slv_ready = 3'b010; slv_rdata[32*1 +: 32] = 32'h55;
    smp();
    checks++; if (mem_ready !== 1'b0) begin errors++; $display("FAIL rm_stale: got ready=%b, expected 0", mem_ready); end
    next();
    idle_in();
    mem_valid = 1'b1; mem_addr = 32'h0;
    smp();
    checks++; if (slv_valid !== 3'b001 || mem_ready !== 1'b0) begin errors++;
      $display("FAIL rm_bram_req: got valid=%b ready=%b, expected 001/0", slv_valid, mem_ready); end
    next();
    idle_in();
    slv_ready = 3'b001; slv_rdata[31:0] = 32'hCAFE_F00D;
    exp_q.push_back('{rdata: 32'hCAFE_F00D, err: 1'b0});
    smp();
    checks++; if (mem_ready !== 1'b1 || mem_rdata !== 32'hCAFE_F00D) begin errors++;
      $display("FAIL rm_bram_rsp: got ready=%b rdata=%h, expected 1/cafef00d", mem_ready, mem_rdata); end
    next();
    idle_in();
  endtask

  initial begin
    test_reset();
    test_uart_read();
    test_back_to_back();
    test_unmapped();
    test_ignore_other();
    test_timeout();
    test_reset_mid();
    next();
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL sb_drain: %0d responses still outstanding, expected 0", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/mem_router.md
Name: mem_router

Overview:
- Parametrised single-master, NSLV-slave router for the core memory bus (valid/instr/addr/wdata/wstrb -> rdata/ready).
- Replaces the fixed three-way decode with a parameter-driven address map.
- Tracks the one outstanding transaction, so response data and ready come only from the addressed slave.
- Adds an error response for unmapped addresses and a timeout for slaves that never respond.

Parameters:
- NSLV, 3, number of slave ports (1..16).
- SLV_BASE, {NSLV{32'h0}}, packed NSLV x 32 array of inclusive base addresses; slave i occupies SLV_BASE[i] <= addr < SLV_TOP[i].
- SLV_TOP, {NSLV{32'h0}}, packed NSLV x 32 array of exclusive top addresses.
- DEFAULT_SLV, 0, slave index used when no range matches; a value of NSLV means unmapped addresses get an error response.
- TIMEOUT, 1024, cycles in BUSY before a forced error response; 0 disables the timeout.

Ports:
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-low
- mem_valid  in  1  request strobe, one cycle per transaction
- mem_instr  in  1  instruction-fetch qualifier
- mem_addr  in  32  byte address
- mem_wdata  in  32  write data
- mem_wstrb  in  4  byte strobes; 0 = read
- mem_rdata  out  32  response data
- mem_ready  out  1  response strobe, one cycle
- mem_error  out  1  qualifies mem_ready: unmapped access or timeout
- slv_valid  out  NSLV  per-slave request strobe
- slv_instr  out  1  broadcast
- slv_addr  out  32  broadcast
- slv_wdata  out  32  broadcast
- slv_wstrb  out  4  broadcast
- slv_rdata  in  NSLV*32  per-slave response data, slice i = [32*i+31:32*i]
- slv_ready  in  NSLV  per-slave response strobe

Behaviour:
- Decode (combinational): hit[i] = (mem_addr >= SLV_BASE[i]) && (mem_addr < SLV_TOP[i]). Lowest matching index wins. If nothing matches, DEFAULT_SLV is selected.
- Request path adds zero latency. In IDLE, slv_valid[sel] = mem_valid and all other slv_valid bits are 0. The broadcast outputs always mirror the master inputs.
- FSM states: IDLE, BUSY, ERR.
- IDLE, mem_valid, mapped, and slv_ready[sel] also high that cycle: combinational pass-through of that slave's response; stay in IDLE.
- IDLE, mem_valid, mapped, otherwise: register sel into cur, clear the timeout counter, go to BUSY.
- IDLE, mem_valid, unmapped (DEFAULT_SLV == NSLV): no slv_valid is asserted; go to ERR.
- ERR: mem_ready = 1, mem_error = 1, mem_rdata = 0 for exactly one cycle, then IDLE. Unmapped access therefore responds with 1-cycle latency.
- BUSY: mem_ready = slv_ready[cur] and mem_rdata = slv_rdata slice cur, both combinational. When slv_ready[cur] is high, go to IDLE with mem_error = 0.
- BUSY: slv_ready from any slave other than cur is ignored.
- BUSY: the counter increments every cycle. When it reaches TIMEOUT-1 without a response, go to ERR. The response then arrives TIMEOUT+1 cycles after the request.
- A stale slv_ready from a timed-out slave that arrives later (in IDLE without a request) is dropped.
- mem_valid while in BUSY or ERR is a protocol violation: it is not forwarded and no response is generated.
- Outside a response, mem_rdata = 0, mem_ready = 0, mem_error = 0.
- Reset (rst == 0): state = IDLE, cur = 0, counter = 0; all outputs are 0. Reset mid-transaction abandons the transaction, and the slave's later ready is dropped.
- Counter width: $clog2(TIMEOUT+1), saturating, so it never wraps.

Decomposition:
- Shared package configure: the default address-map constants used to build SLV_BASE/SLV_TOP (bram, uart, timer base/top), plus the router state enum.
- Sub-module mem_router_dec: a pure combinational priority decoder taking addr and the map, returning sel and hit_any. It is reused by future multi-master arbitration.

Test Plan:
- Map: NSLV=3 with bram 0x0..0x1000, uart 0x1000..0x1004, timer 0x2000..0x2010; DEFAULT_SLV=3, TIMEOUT=8.
- Read 0x1000; uart ready 3 cycles later with rdata 0x41 -> slv_valid = 3'b010 for 1 cycle; mem_ready 3 cycles later with rdata 0x41; mem_error = 0.
- Read 0x0; bram ready in the same cycle with rdata 0x12345678 -> mem_ready in the same cycle with rdata 0x12345678; FSM stays in IDLE.
- Read 0x3000 (unmapped) -> slv_valid = 0; next cycle mem_ready = 1, mem_error = 1, rdata = 0.
- Read 0x2000 while uart pulses slv_ready with 0xFF, then timer responds with 0x7 -> uart response ignored; only 0x7 is returned.
- Read 0x2004 with the timer never responding -> mem_ready + mem_error at request+9 cycles; a timer ready at +12 is not propagated.
- Assert rst = 0 while in BUSY, then release -> all outputs 0; the later slave ready is dropped; a following read of 0x0 completes normally.
